sw_led_port: RTL
================

# sw_led_port

Processor-side end of the board switch/LED interface that `Semi_Procesador_64` exposes as `SW[7:0]` / `LEDS[7:0]`. Synchronizes and debounces the raw switch bus and turns each accepted switch change into an event in a small show-ahead FIFO, which the processor core pops through a valid/read handshake. It also holds the LED output register that the core writes. It sits between the top-level pins and the core's I/O decode.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive cycles a new synchronized switch value must hold before acceptance (>=1)
- `FIFO_DEPTH`, 4, event FIFO entries (power of 2, >=2)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `SW`  in  8  raw switch bus, asynchronous to `clk`
- `rd_en`  in  1  core pops head event; ignored when `rd_valid`=0
- `rd_data`  out  8  head event value (show-ahead); 0 when empty
- `rd_valid`  out  1  FIFO non-empty
- `led_we`  in  1  LED register write strobe
- `led_data`  in  8  LED write value
- `LEDS`  out  8  LED register
- `overflow`  out  1  sticky: an event was dropped on full FIFO
- `ovf_clr`  in  1  clears `overflow`

## Operation
- Synchronizer: 2 flops `s1`, `s2` on `SW`; all logic downstream uses `s2` only.
- Debounce FSM, registers `accepted[7:0]`, `cand[7:0]`, `cnt`:
  - STABLE: `s2`==`accepted`. If `s2`!=`accepted`: `cand`<=`s2`, `cnt`<=1, go COUNT (or accept at once if DEBOUNCE_CYCLES=1).
  - COUNT: if `s2`==`accepted` -> STABLE (glitch discarded, no event). Else if `s2`!=`cand` -> `cand`<=`s2`, `cnt`<=1 (restart). Else if `cnt`==DEBOUNCE_CYCLES-1 -> `accepted`<=`cand`, push `cand`, go STABLE. Else `cnt`++.
  - `cnt` width clog2(DEBOUNCE_CYCLES+1). Every accepted change is pushed, including a return to 0.
- FIFO: circular buffer, read/write pointers with one extra wrap bit; full = pointers equal except MSB; empty = equal.
  - Push with FIFO not full: store. Push on full with no pop the same cycle: value dropped, `overflow`<=1.
  - Push and pop in the same cycle: both happen, including when full (slot freed) and when count is 1.
  - `rd_en` when empty: no effect, pointers unchanged.
- `overflow`: set on a drop, cleared by `ovf_clr`; set wins if both happen in the same cycle.
- LEDS: `led_we`=1 loads `led_data` at the edge. No other path writes `LEDS`.

## Timing
- Reset (async assert, sync-released usage): `s1`,`s2`,`accepted`,`cand`,`cnt`=0, FSM=STABLE, FIFO empty, `rd_valid`=0, `rd_data`=0, `overflow`=0, `LEDS`=0.
- Latency: edge E0 first samples a new `SW` into `s1`. If it holds, `rd_valid` is high after edge E0+1+DEBOUNCE_CYCLES (E0+5 at default).
- Pop: `rd_en` at edge E -> next entry (or `rd_valid`=0) visible after E. `rd_data` is combinational from the head slot.
- `LEDS` is valid one edge after `led_we`.
- Reset mid-debounce discards the candidate. A nonzero `SW` held through reset release produces one event after the normal latency, since `accepted` is 0.

## Structure
- Shared package `io_pkg`: `SW_W`=8, `LED_W`=8, debounce state enum {ST_STABLE, ST_COUNT}.
- One sub-module `sw_event_fifo` (parameterized depth/width, push/pop/full/empty/count). Synchronizer, debounce and LED register stay in the top module.

## Test plan
- Reset release with `SW`=0, hold 20 cycles -> `rd_valid`=0, `LEDS`=0, `overflow`=0.
- `SW`=8'd2 held 10 cycles, then 8'd0 held 10 cycles; pop each when valid -> events 0x02 then 0x00; first `rd_valid` exactly 5 edges after first sampling edge.
- `SW`=8'd4 for 2 cycles then back to 0 (shorter than debounce) -> no event. `SW` 4 for 2 cycles then 6 held -> single event 0x06.
- Generate 5 accepted changes (1,2,3,4,5) with no pops, DEPTH=4 -> FIFO holds 1..4, `overflow`=1. Then push 6 with simultaneous pop -> 2,3,4,6 retained. `ovf_clr` -> `overflow`=0.
- `led_write` 0xA5, then 0x3C; `rd_en` while empty -> `LEDS`=0xA5, then 0x3C one edge after each strobe; FIFO unaffected.
- Assert `rst_n`=0 mid-COUNT with 2 events queued -> all outputs 0 immediately (asynchronously). After release with `SW`=0x80 held -> one event 0x80.

Source files
------------

// File: rtl/io_pkg.sv
// Shared widths and the debounce state encoding for the switch/LED port.
package io_pkg;

    localparam int SW_W  = 8;
    localparam int LED_W = 8;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } deb_state_t;

endpackage

// File: rtl/sw_event_fifo.sv
// Show-ahead circular FIFO holding accepted switch events.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sw_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             do_pop;
    logic             do_push;

    assign wr_addr = wr_ptr_reg[AW-1:0];
    assign rd_addr = rd_ptr_reg[AW-1:0];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_addr == rd_addr);
    assign count = wr_ptr_reg - rd_ptr_reg;

    // A pop on a full FIFO frees the slot the simultaneous push will reuse.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is read combinationally; an empty FIFO presents zero.
    assign head_data = empty ? '0 : mem[rd_addr];

    // Pointer update on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_addr] <= push_data;
    end

endmodule

// File: rtl/sw_led_port.sv
// Switch synchronizer + debouncer feeding an event FIFO, plus LED register.
module sw_led_port
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SW_W-1:0]  SW,
    input  logic             rd_en,
    output logic [SW_W-1:0]  rd_data,
    output logic             rd_valid,
    input  logic             led_we,
    input  logic [LED_W-1:0] led_data,
    output logic [LED_W-1:0] LEDS,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  s1_reg;
    logic [SW_W-1:0]  s2_reg;
    logic [SW_W-1:0]  accepted_reg, accepted_next;
    logic [SW_W-1:0]  cand_reg,     cand_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    deb_state_t       state_reg,    state_next;
    logic             push_en;
    logic [SW_W-1:0]  push_val;
    logic [LED_W-1:0] leds_reg;
    logic             overflow_reg;

    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          drop;

    // Two-flop synchronizer for the asynchronous switch bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= SW;
            s2_reg <= s1_reg;
        end
    end

    // Debounce state and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_STABLE;
            accepted_reg <= '0;
            cand_reg     <= '0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            accepted_reg <= accepted_next;
            cand_reg     <= cand_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Debounce next-state: a new value must hold DEBOUNCE_CYCLES samples.
    always_comb begin
        state_next    = state_reg;
        accepted_next = accepted_reg;
        cand_next     = cand_reg;
        cnt_next      = cnt_reg;
        push_en       = 1'b0;
        push_val      = cand_reg;
        case (state_reg)
            ST_STABLE: begin
                if (s2_reg != accepted_reg) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accepted_next = s2_reg;
                        push_en       = 1'b1;
                        push_val      = s2_reg;
                    end else begin
                        cand_next  = s2_reg;
                        cnt_next   = CNT_ONE;
                        state_next = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (s2_reg == accepted_reg) begin
                    state_next = ST_STABLE;
                end else if (s2_reg != cand_reg) begin
                    cand_next = s2_reg;
                    cnt_next  = CNT_ONE;
                end else if (cnt_reg == CNT_LAST) begin
                    accepted_next = cand_reg;
                    push_en       = 1'b1;
                    push_val      = cand_reg;
                    state_next    = ST_STABLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: state_next = ST_STABLE;
        endcase
    end

    sw_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SW_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_en),
        .push_data (push_val),
        .pop       (rd_en),
        .head_data (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_valid = (fifo_count != '0);

    // An event is lost only when full and no pop frees a slot this cycle.
    assign drop = push_en && fifo_full && !(rd_en && !fifo_empty);

    // Sticky overflow flag; a new drop takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    // LED output register, written only by the core strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_reg <= '0;
        end else if (led_we) begin
            leds_reg <= led_data;
        end
    end

    assign overflow = overflow_reg;
    assign LEDS     = leds_reg;

endmodule
